// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 keyboard receiver and host transmitter:
//   the transmitter state encoding, the default timing constants (cycles of
//   the 3.5 MHz clk_cpu) and a couple of small helper functions.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_DEV,
        SHIFT,
        WAIT_IDLE,
        ABORT
    } ps2_tx_state_t;

    localparam int unsigned PS2_INHIBIT_CYCLES     = 420;    // 120 us
    localparam int unsigned PS2_FIRST_EDGE_TIMEOUT = 52500;  // 15 ms
    localparam int unsigned PS2_PACKET_TIMEOUT     = 7000;   // 2 ms
    localparam int unsigned PS2_FILTER_CYCLES      = 4;

    function automatic int unsigned ps2_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Odd parity bit for a PS/2 frame.
    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Two-flop synchronizer followed by a debounce: a new line level is
//   accepted only after FILTER_CYCLES consecutive synchronized samples agree.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous, active-high reset
//     raw_in in  asynchronous open-collector line
//     level  out filtered line level (idles high)
//     fall   out one-cycle strobe on a filtered 1->0 transition
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = PS2_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);

    logic          sync0_q;
    logic          sync1_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b1;
            sync1_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= raw_in;
            sync1_q <= sync0_q;
            fall_q  <= 1'b0;
            if (sync1_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                // This is the FILTER_CYCLES-th differing sample in a row.
                level_q <= sync1_q;
                fall_q  <= ~sync1_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Inhibits the bus, issues a request to
//   send, then shifts one byte (LSB first, odd parity, stop) out on the
//   device-generated clock and checks the device ACK.
//   Ports:
//     clk, reset            system clock, synchronous active-high reset
//     tx_data/tx_valid      byte to send, request (taken when tx_ready)
//     tx_ready              high only while idle
//     tx_done / tx_error    one-cycle completion / failure pulses
//     busy                  high whenever a transfer is in progress
//     ps2_clk_in/dat_in     raw bus lines (asynchronous)
//     ps2_clk_oe/dat_oe     1 = pull the corresponding line low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES     = PS2_INHIBIT_CYCLES,
    parameter int unsigned FIRST_EDGE_TIMEOUT = PS2_FIRST_EDGE_TIMEOUT,
    parameter int unsigned PACKET_TIMEOUT     = PS2_PACKET_TIMEOUT,
    parameter int unsigned FILTER_CYCLES      = PS2_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One timer serves the inhibit hold and both timeouts.
    localparam int unsigned TMAX = ps2_max3(INHIBIT_CYCLES, FIRST_EDGE_TIMEOUT, PACKET_TIMEOUT);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    ps2_tx_state_t state_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_inc;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    data_q;
    logic          parity_q;
    logic          tx_ready_q;
    logic          tx_done_q;
    logic          tx_error_q;
    logic          busy_q;
    logic          clk_oe_q;
    logic          dat_oe_q;
    logic          dat_s0_q;
    logic          dat_s1_q;
    logic          clk_level;
    logic          clk_fall;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw_in(ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // Data line only needs synchronizing; it is sampled on filtered clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_s0_q <= 1'b1;
            dat_s1_q <= 1'b1;
        end else begin
            dat_s0_q <= ps2_dat_in;
            dat_s1_q <= dat_s0_q;
        end
    end

    // Saturating increment.
    always_comb begin
        timer_inc = timer_q;
        if (timer_q != TW'(TMAX)) timer_inc = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            busy_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        data_q     <= tx_data;
                        parity_q   <= ps2_odd_parity(tx_data);
                        timer_q    <= '0;
                        bit_cnt_q  <= '0;
                        clk_oe_q   <= 1'b1;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // clk_fall is ignored here: the host inhibit wins.
                    if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= REQ;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                REQ: begin
                    clk_oe_q <= 1'b0;
                    timer_q  <= '0;
                    state_q  <= WAIT_DEV;
                end
                WAIT_DEV: begin
                    if (clk_fall) begin
                        dat_oe_q  <= ~data_q[0];
                        bit_cnt_q <= 4'd1;
                        timer_q   <= '0;
                        state_q   <= SHIFT;
                    end else if (timer_inc == TW'(FIRST_EDGE_TIMEOUT)) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        state_q  <= ABORT;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                SHIFT: begin
                    timer_q <= timer_inc;
                    if (clk_fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        case (bit_cnt_q)
                            4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7: dat_oe_q <= ~data_q[bit_cnt_q[2:0]];
                            4'd8:             dat_oe_q <= ~parity_q;
                            4'd9:             dat_oe_q <= 1'b0;
                            4'd10: begin
                                // Device ACK is a low data line on the 11th edge.
                                if (!dat_s1_q) begin
                                    state_q <= WAIT_IDLE;
                                end else begin
                                    dat_oe_q <= 1'b0;
                                    state_q  <= ABORT;
                                end
                            end
                            default: begin
                                dat_oe_q <= 1'b0;
                                state_q  <= ABORT;
                            end
                        endcase
                    end else if (timer_inc == TW'(PACKET_TIMEOUT)) begin
                        dat_oe_q <= 1'b0;
                        state_q  <= ABORT;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && dat_s1_q) begin
                        tx_done_q  <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (timer_inc == TW'(PACKET_TIMEOUT)) begin
                        state_q <= ABORT;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                ABORT: begin
                    clk_oe_q   <= 1'b0;
                    dat_oe_q   <= 1'b0;
                    tx_error_q <= 1'b1;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    clk_oe_q   <= 1'b0;
                    dat_oe_q   <= 1'b0;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = tx_ready_q;
    assign tx_done    = tx_done_q;
    assign tx_error   = tx_error_q;
    assign busy       = busy_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
